// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RD_MSB  = 11;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

endpackage

// File: rtl/multicycle_core_sequencer.sv
// Multi-cycle PC / stage sequencer: owns PC, IR, ALU-out and write-back latches,
// the stage FSM and the req/ack handshakes to instruction and data memory.
module multicycle_core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    input  logic                dec_reg_write,
    input  logic                dec_is_load,
    input  logic                dec_is_store,
    input  logic                dec_is_branch,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                alu_zero,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     rs2_data,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_ack,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [XLEN-1:0]     pc,
    input  logic                halt_req,
    output logic                halted,
    output logic                trap,
    output logic                retire,
    output logic [CNT_W-1:0]    instret
);

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target;
    logic            do_retire;
    logic            set_trap;
    logic            fetch_done;
    logic            mem_done;

    assign imem_addr  = pc;
    assign rf_waddr   = instr[RD_MSB:RD_LSB];
    assign pc_inc     = pc + XLEN'(PC_STEP);
    assign target     = pc + imm;
    // imem_req is low for the first FETCH cycle after reset, so no ack is taken then
    assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
    assign mem_done   = (state == S_MEM) && dmem_req && dmem_ack;

    // Next-state, next-PC and retire decision
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        do_retire = 1'b0;
        set_trap  = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_done) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (dec_is_branch) begin
                    if (alu_zero && (target[1:0] != 2'b00)) begin
                        set_trap  = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = alu_zero ? target : pc_inc;
                        do_retire = 1'b1;
                    end
                end else if (dec_is_load || dec_is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    if (dec_is_store) begin
                        pc_nxt    = pc_inc;
                        do_retire = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_nxt    = pc_inc;
                do_retire = 1'b1;
            end
            S_HALT: begin
                if (!halt_req && !trap) state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
        if (do_retire) state_nxt = halt_req ? S_HALT : S_FETCH;
    end

    // State, latches and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            instr      <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rf_wdata   <= '0;
            instret    <= '0;
            trap       <= 1'b0;
            retire     <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            trap     <= trap | set_trap;
            retire   <= do_retire;
            imem_req <= (state_nxt == S_FETCH);
            dmem_req <= (state_nxt == S_MEM);
            dmem_we  <= (state_nxt == S_MEM) && dec_is_store;
            halted   <= (state_nxt == S_HALT);
            rf_we    <= (state_nxt == S_WB) && dec_reg_write
                        && (instr[RD_MSB:RD_LSB] != 5'd0);
            if (do_retire) instret <= instret + CNT_W'(1);
            if (fetch_done) instr <= imem_rdata;
            if (state == S_EXECUTE) begin
                dmem_addr  <= alu_result;
                dmem_wdata <= rs2_data;
            end
            // Write-back latch: memory data for loads, ALU-out otherwise
            if (state_nxt == S_WB) begin
                rf_wdata <= (state == S_MEM) ? dmem_rdata : alu_result;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_core_sequencer.sv
// Directed scoreboard bench for multicycle_core_sequencer (XLEN=32, CNT_W=4).
module tb_multicycle_core_sequencer;

    localparam int unsigned XL = 32;

    typedef struct {
        logic [XL-1:0] pc;
        logic [3:0]    cnt;
    } ret_t;

    typedef struct {
        logic [4:0]    addr;
        logic [XL-1:0] data;
    } rf_t;

    typedef struct {
        logic          we;
        logic [XL-1:0] addr;
        logic [XL-1:0] wdata;
    } dm_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [XL-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic          dec_reg_write, dec_is_load, dec_is_store, dec_is_branch;
    logic [XL-1:0] alu_result;
    logic          alu_zero;
    logic [XL-1:0] imm;
    logic [XL-1:0] rs2_data;
    logic          dmem_req, dmem_we;
    logic [XL-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack;
    logic [XL-1:0] dmem_rdata;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [XL-1:0] rf_wdata;
    logic [XL-1:0] pc;
    logic          halt_req;
    logic          halted, trap, retire;
    logic [3:0]    instret;

    int checks   = 0;
    int failures = 0;

    ret_t ret_q[$];
    rf_t  rf_q[$];
    dm_t  dm_q[$];

    logic [XL-1:0] m_pc;
    logic [3:0]    m_cnt;
    logic          dm_prev;

    multicycle_core_sequencer #(
        .XLEN     (XL),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .dec_reg_write (dec_reg_write),
        .dec_is_load   (dec_is_load),
        .dec_is_store  (dec_is_store),
        .dec_is_branch (dec_is_branch),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .imm           (imm),
        .rs2_data      (rs2_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pc            (pc),
        .halt_req      (halt_req),
        .halted        (halted),
        .trap          (trap),
        .retire        (retire),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge and pop the scoreboards
    task automatic tick();
        ret_t r;
        rf_t  f;
        dm_t  d;
        @(posedge clk);
        #1;
        if (rf_we) begin
            if (rf_q.size() == 0) begin
                chk("rf_we_unexpected", rf_we, 0);
            end else begin
                f = rf_q.pop_front();
                chk("rf_waddr", rf_waddr, f.addr);
                chk("rf_wdata", rf_wdata, f.data);
            end
        end
        if (retire) begin
            if (ret_q.size() == 0) begin
                chk("retire_unexpected", retire, 0);
            end else begin
                r = ret_q.pop_front();
                chk("retire_pc", pc, r.pc);
                chk("instret", instret, r.cnt);
            end
        end
        if (dmem_req && !dm_prev) begin
            if (dm_q.size() == 0) begin
                chk("dmem_req_unexpected", dmem_req, 0);
            end else begin
                d = dm_q.pop_front();
                chk("dmem_we", dmem_we, d.we);
                chk("dmem_addr", dmem_addr, d.addr);
                chk("dmem_wdata", dmem_wdata, d.wdata);
            end
        end
        dm_prev = dmem_req;
    endtask

    task automatic wait_fetch();
        int w = 0;
        while (!imem_req && w < 20) begin
            tick();
            w++;
        end
        chk("imem_req_up", imem_req, 1);
    endtask

    // Fetch and run one instruction; model expectations are queued before driving
    task automatic do_instr(input logic [31:0] iw, input logic rw, input logic ld,
                            input logic st, input logic br, input logic z,
                            input logic [XL-1:0] alu, input logic [XL-1:0] im,
                            input logic [XL-1:0] rs2, input logic [XL-1:0] rdata,
                            input int iwait, input int dwait);
        logic [XL-1:0] tgt, npc;
        logic          trapx, wr;
        int            lat, dreq, rf_at, exp_lat;
        ret_t r;
        rf_t  f;
        dm_t  d;
        tgt   = m_pc + im;
        trapx = br && z && (tgt[1:0] != 2'b00);
        npc   = (br && z) ? tgt : m_pc + XL'(4);
        wr    = !br && !st && rw && (iw[11:7] != 5'd0);
        if (!trapx) begin
            r.pc  = npc;
            r.cnt = m_cnt + 4'd1;
            ret_q.push_back(r);
        end
        if (wr) begin
            f.addr = iw[11:7];
            f.data = ld ? rdata : alu;
            rf_q.push_back(f);
        end
        if (!br && (ld || st)) begin
            d.we    = st;
            d.addr  = alu;
            d.wdata = rs2;
            dm_q.push_back(d);
        end
        exp_lat = br ? 3 : (ld ? 5 + dwait : (st ? 4 + dwait : 4));

        wait_fetch();
        for (int i = 0; i < iwait; i++) begin
            chk("imem_addr_hold", imem_addr, m_pc);
            tick();
            chk("imem_req_hold", imem_req, 1);
        end
        chk("imem_addr", imem_addr, m_pc);
        imem_ack      = 1'b1;
        imem_rdata    = iw;
        dec_reg_write = rw;
        dec_is_load   = ld;
        dec_is_store  = st;
        dec_is_branch = br;
        alu_zero      = z;
        alu_result    = alu;
        imm           = im;
        rs2_data      = rs2;
        lat   = 0;
        dreq  = 0;
        rf_at = -1;
        do begin
            tick();
            lat++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                dreq++;
                chk("dmem_addr_hold", dmem_addr, alu);
                if (dreq > dwait) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            if (rf_we) rf_at = lat;
        end while (!(retire || halted) && lat < 40);
        chk("latency", lat, exp_lat);
        if (!br && (ld || st)) chk("dmem_req_cycles", dreq, dwait + 1);
        if (wr) chk("rf_we_cycle", rf_at, exp_lat - 1);
        chk("trap", trap, trapx);
        if (!trapx) begin
            m_pc  = npc;
            m_cnt = m_cnt + 4'd1;
        end
    endtask

    initial begin
        dm_t d;
        reset = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        dec_reg_write = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_branch = 1'b0;
        alu_result = '0; alu_zero = 1'b0; imm = '0; rs2_data = '0;
        dmem_ack = 1'b0; dmem_rdata = '0; halt_req = 1'b0;
        m_pc = '0; m_cnt = '0; dm_prev = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_instret", instret, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_retire", retire, 0);
        chk("rst_trap", trap, 0);
        chk("rst_instr", instr, 0);
        #2 reset = 1'b1;

        // ADD x3, single-cycle fetch
        do_instr(32'h0020_81B3, 1, 0, 0, 0, 0, 32'd5, '0, '0, '0, 0, 0);
        // Load x5 with three wait states
        do_instr(32'h0000_2283, 1, 1, 0, 0, 0, 32'h100, '0, '0, 32'hDEAD, 0, 3);
        // Taken branches: 0x08 -> 0x40 -> 0x38
        do_instr(32'h0000_0063, 0, 0, 0, 1, 1, '0, 32'h38, '0, '0, 0, 0);
        do_instr(32'h0000_0063, 0, 0, 0, 1, 1, '0, 32'hFFFF_FFF8, '0, '0, 0, 0);
        chk("pc_after_back_branch", pc, 32'h38);

        // Store with slow fetch and one data wait state, halting at retire
        halt_req = 1'b1;
        do_instr(32'h0000_0023, 1, 0, 1, 0, 0, 32'h80, '0, 32'h55, '0, 2, 1);
        chk("halted_after_store", halted, 1);
        repeat (3) begin
            tick();
            chk("halt_hold", halted, 1);
            chk("halt_no_fetch", imem_req, 0);
        end
        halt_req = 1'b0;

        // Branch to 0xFFFFFFFC, then ALU ops wrap pc to 0 and instret past 15
        do_instr(32'h0000_0063, 0, 0, 0, 1, 1, '0, 32'hFFFF_FFC0, '0, '0, 0, 0);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            if (i == 3)
                do_instr(32'h0000_0063, 0, 0, 0, 1, 0, '0, 32'h100, '0, '0, 0, 0);
            else if (i == 5)
                do_instr(32'h0000_0033, 1, 0, 0, 0, 0, 32'h77, '0, '0, '0, 0, 0);
            else
                do_instr(32'((i + 1) << 7) | 32'h33, 1, 0, 0, 0, 0, 32'(i * 17), '0, '0, '0, 0, 0);
        end
        chk("instret_wrapped", instret, 0);

        // Reset while a load is waiting in MEM
        wait_fetch();
        chk("ld_fetch_addr", imem_addr, m_pc);
        d.we = 1'b0; d.addr = 32'h200; d.wdata = '0;
        dm_q.push_back(d);
        imem_ack = 1'b1; imem_rdata = 32'h0000_3303;
        dec_reg_write = 1'b1; dec_is_load = 1'b1; dec_is_store = 1'b0; dec_is_branch = 1'b0;
        alu_result = 32'h200; rs2_data = '0; alu_zero = 1'b0;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        chk("mem_before_reset", dmem_req, 1);
        #3 reset = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBAD0;
        #1;
        chk("midrst_dmem_req", dmem_req, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_imem_req", imem_req, 0);
        chk("midrst_instret", instret, 0);
        m_pc = '0;
        m_cnt = '0;
        tick();
        tick();
        chk("inrst_dmem_req", dmem_req, 0);
        #2 reset = 1'b1;
        tick();
        chk("post_rst_dmem_req", dmem_req, 0);
        chk("post_rst_imem_req", imem_req, 1);
        chk("post_rst_imem_addr", imem_addr, 0);
        chk("post_rst_instr", instr, 0);
        dmem_ack = 1'b0;

        // Misaligned taken branch traps and stays halted
        do_instr(32'h0000_0063, 0, 0, 0, 1, 1, '0, 32'd6, '0, '0, 0, 0);
        chk("trap_halted", halted, 1);
        repeat (4) begin
            tick();
            chk("trap_hold_halted", halted, 1);
            chk("trap_hold_trap", trap, 1);
            chk("trap_no_fetch", imem_req, 0);
            chk("trap_pc", pc, 0);
            chk("trap_instret", instret, 0);
        end
        reset = 1'b0;
        #1;
        chk("trap_cleared", trap, 0);
        chk("halt_cleared", halted, 0);
        #2 reset = 1'b1;

        chk("ret_q_drained", ret_q.size(), 0);
        chk("rf_q_drained", rf_q.size(), 0);
        chk("dm_q_drained", dm_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_core_sequencer.md
Name: multicycle_core_sequencer

Overview:
- Multi-cycle successor to the single-cycle datapath's PC/write-back control.
- Owns PC, the instruction register (IR), the ALU-out and memory-data latches, the stage FSM and the req/ack handshakes to instruction and data memory.
- Sits between the fetch/memory ports and the existing decode, execute and register-file logic.
- Parametrised in data width, reset vector and retired-instruction counter width; adds variable-latency memory, a branch-alignment trap and halt.

Parameters:
XLEN, 64, datapath/address width
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address (= pc)
imem_ack  input  1  fetch data valid
imem_rdata  input  32  fetched instruction
instr  output  32  IR contents, to decoder
dec_reg_write  input  1  decoded RegWrite
dec_is_load  input  1  decoded load
dec_is_store  input  1  decoded store
dec_is_branch  input  1  decoded conditional branch
alu_result  input  XLEN  execute-stage result
alu_zero  input  1  execute-stage zero flag
imm  input  XLEN  sign-extended immediate
rs2_data  input  XLEN  store data
dmem_req  output  1  data request
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  XLEN  ALU-out latch
dmem_wdata  output  XLEN  latched rs2_data
dmem_ack  input  1  data transaction done
dmem_rdata  input  XLEN  load data
rf_we  output  1  register-file write enable
rf_waddr  output  5  IR[11:7]
rf_wdata  output  XLEN  write-back data
pc  output  XLEN  current PC
halt_req  input  1  stop after current instruction
halted  output  1  FSM in HALT
trap  output  1  sticky misaligned-branch flag
retire  output  1  one-cycle pulse per completed instruction
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, async): pc=RESET_PC; IR, ALU-out, MDR, instret=0; state=FETCH; trap=0; all req/we/retire outputs=0 immediately, including mid-transaction. Memory ack arriving during reset is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ack.
  - On ack: IR<=imem_rdata; go to DECODE.
  - Ack in the same cycle req rises is legal (1-cycle fetch).
- DECODE: one cycle, no outputs; always go to EXECUTE.
- EXECUTE: one cycle; latch aluout<=alu_result, wdata_q<=rs2_data.
  - Branch, taken (alu_zero=1): target=pc+imm, wrapping mod 2^XLEN.
    - If target[1:0]!=0: trap<=1, go to HALT, no retire.
    - Otherwise: pc<=target, retire, go to FETCH.
  - Branch, not taken: pc<=pc+4, retire, go to FETCH.
  - Load or store: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - dmem_req=1, dmem_we=dec_is_store, addr/wdata from latches, held until dmem_ack.
  - On ack, store: pc<=pc+4, retire, go to FETCH.
  - On ack, load: MDR<=dmem_rdata, go to WB.
- WB: one cycle.
  - rf_we = dec_reg_write && IR[11:7]!=0.
  - rf_wdata = load ? MDR : aluout.
  - pc<=pc+4, retire, go to FETCH.
- Decoder inputs must stay stable from DECODE through WB; they are driven from IR, so this holds.
- Retire cycle:
  - retire=1 and instret<=instret+1, wrapping at 2^CNT_W.
  - If halt_req=1 in that cycle, next state is HALT instead of FETCH.
- HALT:
  - halted=1, no requests.
  - Leave to FETCH when halt_req=0 and trap=0.
  - A trap halt is exited only by reset.
- pc increment wraps mod 2^XLEN.
- Minimum latencies with same-cycle ack:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.

Decomposition:
- Shared package core_pkg holds:
  - state enum (encoding above),
  - instruction-field index constants (RD_LSB=7, RD_MSB=11),
  - INSTR_W=32, PC_STEP=4.
- Optional sub-module mem_handshake: one req/ack holder, instantiated twice (imem, dmem).
- All else inline.

Test Plan:
- ADD retire: reset release, imem_ack same cycle, IR=0x002081B3, alu_result=5, dec_reg_write=1 -> rf_we=1, rf_waddr=3, rf_wdata=5 in cycle 4 after fetch start; pc 0->4; instret=1.
- Load with wait states: dmem_ack delayed 3 cycles, alu_result=0x100, dmem_rdata=0xDEAD -> dmem_req held 4 cycles, dmem_addr=0x100, dmem_we=0; then rf_wdata=0xDEAD; 8 cycles total.
- Branch taken and misaligned: pc=0x40, imm=-8, alu_zero=1 -> pc=0x38, retire. Repeat with imm=6 -> trap=1, halted=1, no retire; holds until reset.
- Store, then halt: dec_is_store=1, rs2_data=0x55, halt_req=1 at retire -> dmem_we=1, dmem_wdata=0x55, rf_we never 1, halted=1. Drop halt_req -> FETCH resumes at pc+4.
- Reset mid-MEM: reset=0 while dmem_req=1 -> dmem_req=0 the same cycle, pc=RESET_PC. Late dmem_ack ignored; fetch restarts at RESET_PC after release.
- Wrap: pc=2^XLEN-4 non-branch -> pc=0. With CNT_W=4, instret=15 -> 0 on next retire.
